// File: rtl/keypad_hex_capture.sv
// 4x4 hex keypad scanner: column scan, press/release debounce, and a two-key capture byte
// {previous, newest} for the 7-segment display stage.
module keypad_hex_capture #(
    parameter int unsigned SCAN_DIV        = 1000,
    parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] row_i,
    output logic [3:0] col_o,
    input  logic       clear_i,
    output logic [7:0] data_o,
    output logic [3:0] key_code_o,
    output logic       key_valid_o
);

    localparam int unsigned DwellW = $clog2(SCAN_DIV) + 1;
    localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DwellW-1:0] DwellLast = DwellW'(SCAN_DIV - 1);
    localparam logic [DbW-1:0]    DbLast    = DbW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {StScan, StPressDb, StHeld} state_e;

    state_e            state_q, state_d;
    logic [3:0]        row_meta_q;
    logic [3:0]        rows_s_q;
    logic [1:0]        col_q, col_d;
    logic [DwellW-1:0] dwell_q, dwell_d;
    logic [DbW-1:0]    db_q, db_d;
    logic [3:0]        pat_q, pat_d;
    logic [1:0]        row_idx_q, row_idx_d;
    logic [7:0]        data_q, data_d;
    logic [3:0]        code_q, code_d;
    logic              valid_q, valid_d;
    logic [1:0]        low_row;
    logic              accept;

    // Lowest-index low row wins when several rows read low.
    always_comb begin
        low_row = 2'd0;
        if (!rows_s_q[0])      low_row = 2'd0;
        else if (!rows_s_q[1]) low_row = 2'd1;
        else if (!rows_s_q[2]) low_row = 2'd2;
        else if (!rows_s_q[3]) low_row = 2'd3;
    end

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        dwell_d   = dwell_q;
        db_d      = db_q;
        pat_d     = pat_q;
        row_idx_d = row_idx_q;
        data_d    = data_q;
        code_d    = code_q;
        valid_d   = 1'b0;
        accept    = 1'b0;

        unique case (state_q)
            StScan: begin
                if (dwell_q >= DwellLast) begin
                    dwell_d = '0;
                    if (rows_s_q != 4'hF) begin
                        state_d   = StPressDb;
                        pat_d     = rows_s_q;
                        row_idx_d = low_row;
                        db_d      = '0;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            StPressDb: begin
                if (rows_s_q == pat_q) begin
                    if (db_q >= DbLast) begin
                        accept  = 1'b1;
                        state_d = StHeld;
                        db_d    = '0;
                    end else begin
                        db_d = db_q + 1'b1;
                    end
                end else begin
                    state_d = StScan;
                    db_d    = '0;
                    dwell_d = '0;
                    col_d   = col_q + 2'd1;
                end
            end
            StHeld: begin
                // Column stays put; only a full, stable release re-arms scanning.
                if (rows_s_q == 4'hF) begin
                    if (db_q >= DbLast) begin
                        state_d = StScan;
                        db_d    = '0;
                        dwell_d = '0;
                        col_d   = col_q + 2'd1;
                    end else begin
                        db_d = db_q + 1'b1;
                    end
                end else begin
                    db_d = '0;
                end
            end
            default: state_d = StScan;
        endcase

        if (accept) begin
            valid_d = 1'b1;
            code_d  = {row_idx_q, col_q};
            data_d  = {data_q[3:0], row_idx_q, col_q};
        end
        if (clear_i) begin
            data_d = 8'h00;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            row_meta_q <= 4'hF;
            rows_s_q   <= 4'hF;
            state_q    <= StScan;
            col_q      <= 2'd0;
            dwell_q    <= '0;
            db_q       <= '0;
            pat_q      <= 4'hF;
            row_idx_q  <= 2'd0;
            data_q     <= 8'h00;
            code_q     <= 4'h0;
            valid_q    <= 1'b0;
        end else begin
            row_meta_q <= row_i;
            rows_s_q   <= row_meta_q;
            state_q    <= state_d;
            col_q      <= col_d;
            dwell_q    <= dwell_d;
            db_q       <= db_d;
            pat_q      <= pat_d;
            row_idx_q  <= row_idx_d;
            data_q     <= data_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
        end
    end

    assign col_o       = ~(4'b0001 << col_q);
    assign data_o      = data_q;
    assign key_code_o  = code_q;
    assign key_valid_o = valid_q;

endmodule

// File: tb/tb_keypad_hex_capture.sv
// Bench for keypad_hex_capture: a physical keypad model drives row_i from col_o; expected
// results come from key-press events (code = 4*row+col, byte = {previous, newest}).
module tb_keypad_hex_capture;

    logic       clk_i   = 1'b0;
    logic       rst_i   = 1'b0;
    logic       clear_i = 1'b0;
    logic [3:0] row_i;
    logic [3:0] col_o;
    logic [7:0] data_o;
    logic [3:0] key_code_o;
    logic       key_valid_o;

    logic [15:0] keys = 16'h0000;
    logic [7:0]  model_data = 8'h00;
    logic [3:0]  model_code = 4'h0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          pulses = 0;
    int          n_acc = 0;

    typedef struct {
        int         key;
        int         hold;
        int         exp_pulses;
        logic [3:0] exp_code;
        logic [7:0] exp_data;
    } vec_t;
    vec_t tbl[4];

    keypad_hex_capture #(
        .SCAN_DIV(4),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .row_i(row_i),
        .col_o(col_o),
        .clear_i(clear_i),
        .data_o(data_o),
        .key_code_o(key_code_o),
        .key_valid_o(key_valid_o)
    );

    always #5 clk_i = ~clk_i;

    // Key k sits at row k/4, column k%4; a pressed key pulls its row low when its column is driven.
    always_comb begin
        row_i = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[4*r+c] && !col_o[c]) row_i[r] = 1'b0;
            end
        end
    end

    always @(negedge clk_i) begin
        if (key_valid_o === 1'b1) pulses <= pulses + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic press(input int k, input int hold, input int rel);
        keys[k] = 1'b1;
        step(hold);
        keys[k] = 1'b0;
        step(rel);
    endtask

    task automatic do_reset();
        keys = 16'h0000;
        #2 rst_i = 1'b1;
        step(2);
        rst_i = 1'b0;
        model_data = 8'h00;
        model_code = 4'h0;
    endtask

    task automatic model_accept(input int k);
        model_code = 4'(k);
        model_data = {model_data[3:0], 4'(k)};
    endtask

    task automatic check_press(input string name, input int k, input int hold, input int rel);
        int p0;
        p0 = pulses;
        press(k, hold, rel);
        model_accept(k);
        check({name, " pulses"}, 32'(pulses - p0), 32'd1);
        check({name, " code"}, 32'(key_code_o), 32'(model_code));
        check({name, " data"}, 32'(data_o), 32'(model_data));
    endtask

    initial begin
        int p0;
        int i;
        int n;

        // Asynchronous reset before any clock edge.
        #3 rst_i = 1'b1;
        #1;
        check("reset col", 32'(col_o), 32'hE);
        check("reset data", 32'(data_o), 32'h00);
        check("reset code", 32'(key_code_o), 32'h0);
        check("reset valid", 32'(key_valid_o), 32'h0);
        step(2);
        rst_i = 1'b0;
        step(2);

        // Key 9 (row 2, col 1): one pulse while col 1 is driven, then scanning resumes at col 2.
        keys[9] = 1'b1;
        i = 0;
        while (key_valid_o !== 1'b1 && i < 40) begin
            step(1);
            i++;
        end
        check("key9 seen", 32'(key_valid_o), 32'h1);
        check("key9 col held", 32'(col_o), 32'hD);
        model_accept(9);
        check("key9 code", 32'(key_code_o), 32'h9);
        check("key9 data", 32'(data_o), 32'h09);
        step(40 - i);
        keys[9] = 1'b0;
        step(8);
        check("key9 release debounce", 32'(col_o), 32'hD);
        step(4);
        check("key9 resume col2", 32'(col_o), 32'hB);
        step(20);
        check("key9 pulses", 32'(pulses), 32'd1);

        tbl[0] = '{key: 5,  hold: 40, exp_pulses: 1, exp_code: 4'h5, exp_data: 8'h95};
        tbl[1] = '{key: 14, hold: 40, exp_pulses: 1, exp_code: 4'hE, exp_data: 8'h5E};
        tbl[2] = '{key: 2,  hold: 5,  exp_pulses: 0, exp_code: 4'hE, exp_data: 8'h5E};
        tbl[3] = '{key: 2,  hold: 40, exp_pulses: 1, exp_code: 4'h2, exp_data: 8'hE2};
        for (int t = 0; t < 4; t++) begin
            p0 = pulses;
            press(tbl[t].key, tbl[t].hold, 30);
            check($sformatf("tbl%0d pulses", t), 32'(pulses - p0), 32'(tbl[t].exp_pulses));
            check($sformatf("tbl%0d code", t), 32'(key_code_o), 32'(tbl[t].exp_code));
            check($sformatf("tbl%0d data", t), 32'(data_o), 32'(tbl[t].exp_data));
        end
        model_data = 8'hE2;
        model_code = 4'h2;

        // Bouncing contact on key 6: no pulse while bouncing, exactly one once stable.
        p0 = pulses;
        for (int b = 0; b < 10; b++) begin
            keys[6] = ~keys[6];
            step(3);
        end
        check("bounce no pulse", 32'(pulses - p0), 32'd0);
        keys[6] = 1'b1;
        step(40);
        keys[6] = 1'b0;
        step(30);
        model_accept(6);
        check("bounce pulses", 32'(pulses - p0), 32'd1);
        check("bounce code", 32'(key_code_o), 32'h6);
        check("bounce data", 32'(data_o), 32'(model_data));

        // Asynchronous reset mid-cycle.
        #2 rst_i = 1'b1;
        #1;
        check("midreset col", 32'(col_o), 32'hE);
        check("midreset data", 32'(data_o), 32'h00);
        check("midreset code", 32'(key_code_o), 32'h0);
        check("midreset valid", 32'(key_valid_o), 32'h0);
        step(2);
        rst_i = 1'b0;
        model_data = 8'h00;
        step(2);

        // Long hold of key 0 with key F pressed during the hold.
        p0 = pulses;
        keys[0] = 1'b1;
        step(60);
        keys[15] = 1'b1;
        step(140);
        model_accept(0);
        check("hold pulses", 32'(pulses - p0), 32'd1);
        check("hold code", 32'(key_code_o), 32'h0);
        keys[0] = 1'b0;
        step(60);
        model_accept(15);
        check("second key pulses", 32'(pulses - p0), 32'd2);
        check("second key code", 32'(key_code_o), 32'hF);
        check("second key data", 32'(data_o), 32'(model_data));
        keys[15] = 1'b0;
        step(30);

        // Measure acceptance latency of key 3 after a fixed history (A then 7).
        do_reset();
        press(10, 40, 30);
        press(7, 40, 30);
        keys[3] = 1'b1;
        n = 0;
        for (int c = 1; c <= 80 && n == 0; c++) begin
            step(1);
            if (key_valid_o === 1'b1) n = c;
        end
        check("latency found", 32'(n > 0), 32'd1);
        if (n < 4) n = 12;
        keys[3] = 1'b0;
        step(30);

        // Replay with clear_i in the acceptance cycle.
        do_reset();
        press(10, 40, 30);
        press(7, 40, 30);
        check("before clear data", 32'(data_o), 32'hA7);
        keys[3] = 1'b1;
        p0 = pulses;
        for (int c = 1; c <= n; c++) begin
            if (c == n) clear_i = 1'b1;
            step(1);
            clear_i = 1'b0;
        end
        check("clear+accept valid", 32'(key_valid_o), 32'h1);
        check("clear+accept code", 32'(key_code_o), 32'h3);
        check("clear+accept data", 32'(data_o), 32'h00);
        step(40);
        keys[3] = 1'b0;
        step(30);
        check("clear+accept pulses", 32'(pulses - p0), 32'd1);

        // Replay with reset during press debounce; key held through reset is accepted once.
        do_reset();
        press(10, 40, 30);
        press(7, 40, 30);
        keys[3] = 1'b1;
        p0 = pulses;
        step(n - 3);
        #1 rst_i = 1'b1;
        #1;
        check("db reset col", 32'(col_o), 32'hE);
        check("db reset data", 32'(data_o), 32'h00);
        check("db reset valid", 32'(key_valid_o), 32'h0);
        step(2);
        check("db reset no pulse", 32'(pulses - p0), 32'd0);
        rst_i = 1'b0;
        step(50);
        check("after reset pulses", 32'(pulses - p0), 32'd1);
        check("after reset code", 32'(key_code_o), 32'h3);
        check("after reset data", 32'(data_o), 32'h03);
        keys[3] = 1'b0;
        step(30);

        // Random key sequence against the event-level model, with occasional clears.
        do_reset();
        step(2);
        for (int r = 0; r < 12; r++) begin
            int k;
            int hold;
            k = int'($urandom_range(15));
            hold = int'($urandom_range(70, 40));
            if ($urandom_range(3) == 0) begin
                clear_i = 1'b1;
                step(1);
                clear_i = 1'b0;
                model_data = 8'h00;
                check($sformatf("rnd%0d clear data", r), 32'(data_o), 32'h00);
                check($sformatf("rnd%0d clear code", r), 32'(key_code_o), 32'(model_code));
            end
            check_press($sformatf("rnd%0d key%0d", r, k), k, hold, int'($urandom_range(40, 25)));
            n_acc++;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
